// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: shared AHB-Lite encodings and bus widths
package ahb_lite_pkg;
    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: combinational base/mask decode with lowest-index priority
module ahb_addr_decode
    import ahb_lite_pkg::*;
#(
    parameter int                     NSLV     = 4,
    parameter logic [NSLV*AHB_AW-1:0] SLV_BASE = {32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NSLV*AHB_AW-1:0] SLV_MASK = {NSLV{32'hFFFF_0000}}
) (
    input  logic [AHB_AW-1:0] HADDR,
    output logic [NSLV-1:0]   HSEL,
    output logic              HSELDEF
);
    logic hit;

    // first matching region claims the select so HSEL stays one-hot on overlap
    always_comb begin
        HSEL = '0;
        hit  = 1'b0;
        for (int i = 0; i < NSLV; i++)
            if (!hit && ((HADDR & SLV_MASK[i*AHB_AW +: AHB_AW]) == SLV_BASE[i*AHB_AW +: AHB_AW])) begin
                HSEL[i] = 1'b1;
                hit     = 1'b1;
            end
        HSELDEF = ~hit;
    end
endmodule

// File: rtl/ahb_slave_decode_mux.sv
// ahb_slave_decode_mux: AHB-Lite decoder, data-phase response mux and decode-miss log
module ahb_slave_decode_mux
    import ahb_lite_pkg::*;
#(
    parameter int                     NSLV     = 4,
    parameter logic [NSLV*AHB_AW-1:0] SLV_BASE = {32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NSLV*AHB_AW-1:0] SLV_MASK = {NSLV{32'hFFFF_0000}}
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [AHB_AW-1:0]      HADDR,
    input  logic [1:0]             HTRANS,
    output logic [NSLV-1:0]        HSEL,
    output logic                   HSELDEF,
    input  logic [NSLV-1:0]        HREADYOUT_S,
    input  logic [NSLV-1:0]        HRESP_S,
    input  logic [NSLV*AHB_DW-1:0] HRDATA_S,
    input  logic                   HREADYOUT_DEF,
    input  logic                   HRESP_DEF,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [AHB_DW-1:0]      HRDATA,
    input  logic                   MISS_CLR,
    output logic                   MISS_VALID,
    output logic [AHB_AW-1:0]      MISS_ADDR,
    output logic [7:0]             MISS_CNT
);
    logic [NSLV:0] dsel;
    logic          miss;

    ahb_addr_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .HADDR   (HADDR),
        .HSEL    (HSEL),
        .HSELDEF (HSELDEF)
    );

    assign miss = HREADY & HTRANS[1] & HSELDEF;

    // data-phase owner advances whenever the bus is ready, held through wait states
    always_ff @(posedge HCLK) begin
        if (HRESET)
            dsel <= '0;
        else if (HREADY)
            dsel <= {HSELDEF, HSEL};
    end

    // one-hot AND-OR response mux; an empty dsel looks like an idle OKAY bus
    always_comb begin
        HREADY = ~|dsel | (dsel[NSLV] & HREADYOUT_DEF);
        HRESP  = dsel[NSLV] & HRESP_DEF;
        HRDATA = '0;
        for (int i = 0; i < NSLV; i++) begin
            HREADY = HREADY | (dsel[i] & HREADYOUT_S[i]);
            HRESP  = HRESP | (dsel[i] & HRESP_S[i]);
            HRDATA = HRDATA | ({AHB_DW{dsel[i]}} & HRDATA_S[i*AHB_DW +: AHB_DW]);
        end
    end

    // miss log: a qualifying miss overrides a coincident clear and restarts the count at 1
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            MISS_VALID <= 1'b0;
            MISS_ADDR  <= '0;
            MISS_CNT   <= '0;
        end else if (miss) begin
            MISS_VALID <= 1'b1;
            MISS_ADDR  <= HADDR;
            MISS_CNT   <= MISS_CLR ? 8'd1 : (&MISS_CNT ? MISS_CNT : MISS_CNT + 8'd1);
        end else if (MISS_CLR) begin
            MISS_VALID <= 1'b0;
            MISS_ADDR  <= '0;
            MISS_CNT   <= '0;
        end
    end
endmodule

// File: tb/tb_ahb_slave_decode_mux.sv
// tb_ahb_slave_decode_mux: directed checks of decode, response mux and miss log
module tb_ahb_slave_decode_mux;
    import ahb_lite_pkg::*;

    localparam int NSLV = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [3:0]    HSEL, ov_hsel;
    logic          HSELDEF, ov_hseldef;
    logic [3:0]    HREADYOUT_S;
    logic [3:0]    HRESP_S;
    logic [127:0]  HRDATA_S;
    logic          HREADYOUT_DEF;
    logic          HRESP_DEF;
    logic          HREADY, ov_hready;
    logic          HRESP, ov_hresp;
    logic [31:0]   HRDATA, ov_hrdata;
    logic          MISS_CLR;
    logic          MISS_VALID, ov_miss_valid;
    logic [31:0]   MISS_ADDR, ov_miss_addr;
    logic [7:0]    MISS_CNT, ov_miss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_decode_mux #(
        .NSLV     (NSLV),
        .SLV_BASE ({32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
        .SLV_MASK ({4{32'hFFFF_0000}})
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSEL          (HSEL),
        .HSELDEF       (HSELDEF),
        .HREADYOUT_S   (HREADYOUT_S),
        .HRESP_S       (HRESP_S),
        .HRDATA_S      (HRDATA_S),
        .HREADYOUT_DEF (HREADYOUT_DEF),
        .HRESP_DEF     (HRESP_DEF),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .MISS_CLR      (MISS_CLR),
        .MISS_VALID    (MISS_VALID),
        .MISS_ADDR     (MISS_ADDR),
        .MISS_CNT      (MISS_CNT)
    );

    ahb_slave_decode_mux #(
        .NSLV     (NSLV),
        .SLV_BASE ({32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h4000_0000}),
        .SLV_MASK ({4{32'hFFFF_0000}})
    ) u_ov (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSEL          (ov_hsel),
        .HSELDEF       (ov_hseldef),
        .HREADYOUT_S   (HREADYOUT_S),
        .HRESP_S       (HRESP_S),
        .HRDATA_S      (HRDATA_S),
        .HREADYOUT_DEF (HREADYOUT_DEF),
        .HRESP_DEF     (HRESP_DEF),
        .HREADY        (ov_hready),
        .HRESP         (ov_hresp),
        .HRDATA        (ov_hrdata),
        .MISS_CLR      (MISS_CLR),
        .MISS_VALID    (ov_miss_valid),
        .MISS_ADDR     (ov_miss_addr),
        .MISS_CNT      (ov_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET        = 1'b1;
        HADDR         = 32'h0;
        HTRANS        = HTRANS_IDLE;
        HREADYOUT_S   = 4'hF;
        HRESP_S       = 4'h0;
        HRDATA_S      = {32'hDEAD_0003, 32'hDEAD_0002, 32'hCAFE_0001, 32'hDEAD_0000};
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = 1'b0;
        MISS_CLR      = 1'b0;
        tick();
        tick();
        HRESET      = 1'b0;
        HREADYOUT_S = 4'h0;
        HRESP_S     = 4'hF;
        #1;
        check("rst_hready", HREADY, 1);
        check("rst_hresp", HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_miss_valid", MISS_VALID, 0);
        check("rst_miss_addr", MISS_ADDR, 0);
        check("rst_miss_cnt", MISS_CNT, 0);
        check("rst_hsel_slv0", HSEL, 4'b0001);
        HREADYOUT_S = 4'hF;
        HRESP_S     = 4'h0;

        HADDR  = 32'h2000_0010;
        HTRANS = HTRANS_NONSEQ;
        #1;
        check("rd_hsel", HSEL, 4'b0010);
        check("rd_hseldef", HSELDEF, 0);
        tick();
        HADDR          = 32'h0000_0000;
        HTRANS         = HTRANS_IDLE;
        HREADYOUT_S[1] = 1'b0;
        #1;
        check("rd_wait_hready", HREADY, 0);
        tick();
        HREADYOUT_S[1] = 1'b1;
        HADDR          = 32'h8000_0000;
        HTRANS         = HTRANS_NONSEQ;
        #1;
        check("rd_done_hready", HREADY, 1);
        check("rd_done_hrdata", HRDATA, 32'hCAFE_0001);
        check("rd_done_hresp", HRESP, 0);
        check("miss_hseldef", HSELDEF, 1);
        check("miss_hsel", HSEL, 4'b0000);
        tick();
        HTRANS        = HTRANS_IDLE;
        HADDR         = 32'h8000_0004;
        HREADYOUT_DEF = 1'b0;
        HRESP_DEF     = 1'b1;
        #1;
        check("err1_hready", HREADY, 0);
        check("err1_hresp", HRESP, 1);
        check("err1_hrdata", HRDATA, 0);
        check("miss_addr", MISS_ADDR, 32'h8000_0000);
        check("miss_cnt", MISS_CNT, 1);
        check("miss_valid", MISS_VALID, 1);
        tick();
        HREADYOUT_DEF = 1'b1;
        #1;
        check("err2_hready", HREADY, 1);
        check("err2_hresp", HRESP, 1);
        check("idle_hseldef", HSELDEF, 1);
        tick();
        HRESP_DEF = 1'b0;
        #1;
        check("idle_hready", HREADY, 1);
        check("idle_hresp", HRESP, 0);
        check("idle_miss_cnt", MISS_CNT, 1);
        check("idle_miss_addr", MISS_ADDR, 32'h8000_0000);

        HTRANS = HTRANS_NONSEQ;
        for (int k = 0; k < 300; k++) begin
            HADDR = 32'h8000_0000 + 32'(k * 4);
            tick();
            if (k == 253)
                check("sat_cnt_254", MISS_CNT, 8'd255);
            if (k == 254)
                check("sat_cnt_255", MISS_CNT, 8'd255);
        end
        check("sat_cnt_300", MISS_CNT, 8'd255);
        check("sat_addr_300", MISS_ADDR, 32'h8000_04AC);
        HADDR    = 32'h8000_1000;
        MISS_CLR = 1'b1;
        tick();
        MISS_CLR = 1'b0;
        HTRANS   = HTRANS_IDLE;
        check("clrmiss_cnt", MISS_CNT, 1);
        check("clrmiss_addr", MISS_ADDR, 32'h8000_1000);
        check("clrmiss_valid", MISS_VALID, 1);
        MISS_CLR = 1'b1;
        tick();
        MISS_CLR = 1'b0;
        check("clr_cnt", MISS_CNT, 0);
        check("clr_addr", MISS_ADDR, 0);
        check("clr_valid", MISS_VALID, 0);

        HADDR = 32'h4000_0020;
        #1;
        check("ov_hsel", ov_hsel, 4'b0001);
        check("ov_hseldef", ov_hseldef, 0);
        check("main_hsel_slv2", HSEL, 4'b0100);

        HADDR  = 32'h4000_0000;
        HTRANS = HTRANS_NONSEQ;
        tick();
        HTRANS         = HTRANS_IDLE;
        HREADYOUT_S[2] = 1'b0;
        HRESP_S        = 4'hF;
        #1;
        check("mid_hready", HREADY, 0);
        check("mid_hrdata", HRDATA, 32'hDEAD_0002);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        check("post_rst_hready", HREADY, 1);
        check("post_rst_hresp", HRESP, 0);
        check("post_rst_hrdata", HRDATA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
